// File: rtl/data_ram_resp_pkg.sv
// Shared types and helpers for the data-memory responder and its write buffer.
// Optional feature macro used by this slice: DATA_RAM_WB_COALESCE_EN.
package data_ram_resp_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  // Word index storage is sized for the full 32-bit byte address space so the
  // entry type does not depend on the responder's ADDR_W parameter.
  localparam int IDX_W  = 30;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  word_idx;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Replace the byte lanes of old_data selected by sel with those of new_data.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_data,
    input logic [DATA_W-1:0] new_data,
    input logic [SEL_W-1:0]  sel
  );
    logic [DATA_W-1:0] res;
    res = old_data;
    for (int k = 0; k < SEL_W; k++) begin
      if (sel[k]) begin
        res[8*k +: 8] = new_data[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/data_ram_wb_fifo.sv
// Posted write buffer: circular FIFO of pending byte-masked word writes with a
// per-lane youngest-match lookup used for read forwarding.
// Optional feature macro used by this slice: DATA_RAM_WB_COALESCE_EN (the
// merge port is only driven when it is defined).
module data_ram_wb_fifo
  import data_ram_resp_pkg::*;
#(
  parameter int WB_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  wb_entry_t          push_entry,
  input  logic               pop,
  input  logic               merge,
  input  logic [SEL_W-1:0]   merge_sel,
  input  logic [DATA_W-1:0]  merge_data,
  input  logic [IDX_W-1:0]   lookup_idx,
  output wb_entry_t          head_entry,
  output wb_entry_t          tail_entry,
  output logic               full,
  output logic               empty,
  output logic [WB_LOG2:0]   count,
  output logic [SEL_W-1:0]   fwd_hit,
  output logic [DATA_W-1:0]  fwd_data
);

  localparam int DEPTH = 1 << WB_LOG2;

  wb_entry_t          entries [DEPTH];
  logic [WB_LOG2-1:0] head;
  logic [WB_LOG2-1:0] tail;
  logic [WB_LOG2-1:0] last;
  logic [WB_LOG2-1:0] slot;

  assign last       = tail - WB_LOG2'(1);
  assign full       = (count == (WB_LOG2+1)'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = entries[head];
  assign tail_entry = entries[last];

  // Pointer, occupancy and entry storage; merge rewrites the youngest entry in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (push) begin
        entries[tail] <= push_entry;
        tail          <= tail + WB_LOG2'(1);
      end
      if (merge) begin
        entries[last].sel  <= entries[last].sel | merge_sel;
        entries[last].data <= lane_merge(entries[last].data, merge_data, merge_sel);
      end
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + WB_LOG2'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (WB_LOG2+1)'(1);
        2'b01:   count <= count - (WB_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk entries oldest to youngest so the last matching lane written wins.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + WB_LOG2'(i);
      if (entries[slot].valid && (entries[slot].word_idx == lookup_idx)) begin
        for (int k = 0; k < SEL_W; k++) begin
          if (entries[slot].sel[k]) begin
            fwd_hit[k]         = 1'b1;
            fwd_data[8*k +: 8] = entries[slot].data[8*k +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: word-organised single-port RAM behind a posted write
// buffer, combinational reads with byte-wise forwarding, stall on WB full.
// Optional feature macro: DATA_RAM_WB_COALESCE_EN -- writes to the same word as
// the youngest buffered entry merge into it instead of allocating.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int WB_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               stallreq_o,
  output logic [WB_LOG2:0]   wb_count_o
);

  localparam int RAM_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic [ADDR_W-1:0] ram_idx;
  logic [IDX_W-1:0]  word_idx;
  logic              read_req;
  logic              write_req;
  logic              push;
  logic              pop;
  logic              merge;
  logic              stall;
  logic              full;
  logic              empty;
  logic [WB_LOG2:0]  wb_count;
  wb_entry_t         push_entry;
  wb_entry_t         head_entry;
  wb_entry_t         tail_entry;
  logic [SEL_W-1:0]  fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] ram_word;
  logic [DATA_W-1:0] rd_data;
  logic              unused_bits;

  assign ram_idx   = addr_i[ADDR_W+1:2];
  assign word_idx  = IDX_W'(ram_idx);
  assign read_req  = ce_i && !we_i;
  assign write_req = ce_i && we_i;

  assign push_entry = '{valid: 1'b1, word_idx: word_idx, sel: sel_i, data: data_i};

`ifdef DATA_RAM_WB_COALESCE_EN
  // A merging write is never stalled, and the head only drains on idle or
  // stalled cycles, so the merged entry can never be the one draining now.
  assign merge = write_req && !empty && tail_entry.valid &&
                 (tail_entry.word_idx == word_idx);
  assign unused_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0], head_entry.valid,
                         head_entry.word_idx[IDX_W-1:ADDR_W]};
`else
  assign merge = 1'b0;
  assign unused_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0], head_entry.valid,
                         head_entry.word_idx[IDX_W-1:ADDR_W], tail_entry};
`endif

  // The array port is free whenever no read is in progress, but the buffer
  // only gives up its head on idle cycles or on the stalled write cycle.
  assign stall = write_req && full && !merge;
  assign push  = write_req && !full && !merge;
  assign pop   = !empty && (!ce_i || stall);

  assign ram_word   = ram[ram_idx];
  assign data_o     = (rst && read_req) ? rd_data : '0;
  assign stallreq_o = rst && stall;
  assign wb_count_o = wb_count;

  data_ram_wb_fifo #(
    .WB_LOG2 (WB_LOG2)
  ) u_wb (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .merge      (merge),
    .merge_sel  (sel_i),
    .merge_data (data_i),
    .lookup_idx (word_idx),
    .head_entry (head_entry),
    .tail_entry (tail_entry),
    .full       (full),
    .empty      (empty),
    .count      (wb_count),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
  );

  // Overlay buffered lanes on the array word so reads see every posted write.
  always_comb begin
    rd_data = ram_word;
    for (int k = 0; k < SEL_W; k++) begin
      if (fwd_hit[k]) begin
        rd_data[8*k +: 8] = fwd_data[8*k +: 8];
      end
    end
  end

  // Drain the head entry into the array, touching only its enabled lanes.
  always_ff @(posedge clk) begin
    if (rst && pop) begin
      for (int k = 0; k < SEL_W; k++) begin
        if (head_entry.sel[k]) begin
          ram[head_entry.word_idx[ADDR_W-1:0]][8*k +: 8] <= head_entry.data[8*k +: 8];
        end
      end
    end
  end

endmodule
